cache_bus_arb: RTL and testbench
================================

CACHE_BUS_ARB -- requirements
Module: cachebusarb

Interface
REQ-001 SHALL have parameter: PA_BITS, 34, physical address width.
REQ-002 SHALL have parameter: LOGBWPL, 2, log2 of bus beats per cache line (BEATS = 2^LOGBWPL).
REQ-003 SHALL have ports: clk  in  1  clock; the block uses one clock, and reset is synchronous and active-high.
REQ-004 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: ICacheBusRW  in  2  I$ request, [1] line fetch, [0] writeback; DCacheBusRW  in  2  D$ request, same encoding.
REQ-006 SHALL have ports: ICacheBusAdr, DCacheBusAdr  in  PA_BITS  line-aligned request addresses.
REQ-007 SHALL have ports: BusBeatReady  in  1  memory accepted/returned one beat this cycle.
REQ-008 SHALL have ports: BusReq  out  1  bus active; BusWrite  out  1  1 = writeback burst; BusAdr  out  PA_BITS  owner line address.
REQ-009 SHALL have ports: BeatCount  out  LOGBWPL  current beat; BusLast  out  1  final beat accepted this cycle.
REQ-010 SHALL have ports: ICacheBusAck, DCacheBusAck  out  1  one-cycle burst-complete pulses; ISelBeat, DSelBeat  out  1  BusBeatReady qualified by grant.

Function
REQ-011 SHALL treat a requester as requesting when its RW is nonzero, with RW[0] taking precedence over RW[1] when both are set.
REQ-012 SHALL implement states IDLE, GNT_I, GNT_D, HOLD_D.
REQ-013 SHALL, in IDLE, leave BusReq low and go to GNT_D or GNT_I on the next edge, chosen by the priority rule; with no requests it SHALL stay in IDLE.
REQ-014 SHALL latch the owner's address and its BusWrite value on grant, and hold both for the whole burst.
REQ-015 SHALL, in GNT_*, hold BusReq at 1 and increment BeatCount on each BusBeatReady.
REQ-016 SHALL assert BusLast and the owner's Ack combinationally in the same cycle when BusBeatReady is high and BeatCount = BEATS-1.
REQ-017 SHALL then clear BeatCount to 0 (wrap-around).
REQ-018 SHALL ignore requester RW changes once a grant is taken; a withdrawn request (FlushStage) still completes the burst, and the Ack still pulses.
REQ-019 SHALL, after a D$ writeback burst completes, go to HOLD_D for exactly one cycle, with BusReq low.
REQ-020 SHALL, in HOLD_D, go to GNT_D if DCacheBusRW is nonzero, otherwise go to IDLE; I$ SHALL NOT be granted in HOLD_D.
REQ-021 SHALL, after any other burst, return to IDLE; the minimum gap between bursts is one cycle.
REQ-022 SHALL keep the non-owner's Ack and SelBeat low at all times.
REQ-023 SHALL drive BusAdr, BusWrite and BeatCount as 0 when not granted.

Reset
REQ-024 SHALL, on reset, return to IDLE and clear BeatCount, BusReq, BusLast, both Acks and both SelBeats to 0.
REQ-025 SHALL treat reset asserted mid-burst as aborting the burst with no Ack.
REQ-026 SHALL reset LastOwner to I$.

Configuration
REQ-027 SHALL use macro CACHEBUSARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-028 SHALL, with CACHEBUSARB_ROUND_ROBIN_EN undefined, use fixed priority: D$ wins whenever both request in IDLE.
REQ-029 SHALL, with CACHEBUSARB_ROUND_ROBIN_EN defined, keep a LastOwner flop updated on each grant; when both request in IDLE, the requester that is not LastOwner wins.
REQ-030 SHALL have HOLD_D override the arbitration policy in both configurations.

Verification (LOGBWPL=2, BusBeatReady=1 every cycle unless stated)
REQ-031 SHALL cover: ICacheBusRW=10, Adr=0x80001000, alone -> grant next cycle, BusWrite=0, BeatCount 0..3, ICacheBusAck and BusLast at beat 3, IDLE after.
REQ-032 SHALL cover: both request at the same edge (I=10, D=10), fixed priority -> D$ burst completes first, I$ granted one cycle after DCacheBusAck; with ROUND_ROBIN_EN the same stimulus after reset -> D$ first, and a repeat -> I$ first.
REQ-033 SHALL cover: D=01, then D=10 held after the Ack, while I=10 pending -> writeback burst (BusWrite=1), HOLD_D, D$ fetch burst, then I$ granted.
REQ-034 SHALL cover: BusBeatReady toggling 1,0,1,0,... -> BeatCount advances only on high cycles, Ack on the fourth high cycle, no early Ack.
REQ-035 SHALL cover: reset asserted at BeatCount=2 of a D$ burst -> next cycle IDLE, BeatCount=0, no DCacheBusAck ever pulsed.
REQ-036 SHALL cover: I$ request withdrawn to 00 after grant -> burst runs to 4 beats, ICacheBusAck pulses once.

Source files
------------

// File: rtl/cache_bus_arb.sv
// rtl/cache_bus_arb.sv - two-requester (I$/D$) line-burst bus arbiter
//
// Purpose:
//   Grants a shared memory bus to either the instruction cache or the data
//   cache for one full cache-line burst of BEATS = 2**LOGBWPL beats. Owner
//   address and direction are latched at grant and held for the burst.
//   After a D$ writeback burst the arbiter parks in HOLD_D for one cycle so
//   the D$ can follow up with its line fetch ahead of the I$.
//
// Configuration:
//   CACHEBUSARB_ROUND_ROBIN_EN  defined   -> alternate between requesters
//                                           when both ask in IDLE
//                               undefined -> fixed priority, D$ wins
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ICacheBusRW[1:0]      I$ request: [1] line fetch, [0] writeback
//   DCacheBusRW[1:0]      D$ request, same encoding
//   ICacheBusAdr          I$ line-aligned address
//   DCacheBusAdr          D$ line-aligned address
//   BusBeatReady          memory accepted/returned one beat this cycle
//   BusReq                bus active (granted)
//   BusWrite              1 = writeback burst
//   BusAdr                owner's latched line address
//   BeatCount             current beat index within the burst
//   BusLast               final beat accepted this cycle
//   ICacheBusAck          one-cycle I$ burst-complete pulse
//   DCacheBusAck          one-cycle D$ burst-complete pulse
//   ISelBeat, DSelBeat    BusBeatReady qualified by grant

module cache_bus_arb #(
  parameter int PA_BITS = 34,
  parameter int LOGBWPL = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ICacheBusRW,
  input  logic [1:0]         DCacheBusRW,
  input  logic [PA_BITS-1:0] ICacheBusAdr,
  input  logic [PA_BITS-1:0] DCacheBusAdr,
  input  logic               BusBeatReady,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               BusLast,
  output logic               ICacheBusAck,
  output logic               DCacheBusAck,
  output logic               ISelBeat,
  output logic               DSelBeat
);

  localparam logic [LOGBWPL-1:0] BEAT_ONE  = 1;
  localparam logic [LOGBWPL-1:0] BEAT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_I  = 2'd1,
    GNT_D  = 2'd2,
    HOLD_D = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PA_BITS-1:0]  r_adr;
  logic                r_write;
  logic [LOGBWPL-1:0]  r_beat;

  logic                w_ireq;
  logic                w_dreq;
  logic                w_pick_d;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_last;
  logic                w_owned;

  assign w_ireq = |ICacheBusRW;
  assign w_dreq = |DCacheBusRW;

`ifdef CACHEBUSARB_ROUND_ROBIN_EN
  // 1 = D$ held the most recent grant, 0 = I$.
  logic r_last_d;

  // On contention, the requester that did not own the bus last time wins.
  assign w_pick_d = w_dreq & (~w_ireq | ~r_last_d);
`else
  assign w_pick_d = w_dreq;
`endif

  always_comb begin
    w_next       = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_last       = 1'b0;
    w_owned      = 1'b0;
    BusReq       = 1'b0;
    BusWrite     = 1'b0;
    BusAdr       = '0;
    BeatCount    = '0;
    BusLast      = 1'b0;
    ICacheBusAck = 1'b0;
    DCacheBusAck = 1'b0;
    ISelBeat     = 1'b0;
    DSelBeat     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next    = GNT_D;
          w_grant_d = 1'b1;
        end else if (w_ireq) begin
          w_next    = GNT_I;
          w_grant_i = 1'b1;
        end
      end

      GNT_I, GNT_D: begin
        w_owned   = 1'b1;
        BusReq    = 1'b1;
        BusWrite  = r_write;
        BusAdr    = r_adr;
        BeatCount = r_beat;
        w_last    = BusBeatReady && (r_beat == BEAT_LAST);
        BusLast   = w_last;
        if (r_state == GNT_I) begin
          ISelBeat     = BusBeatReady;
          ICacheBusAck = w_last;
        end else begin
          DSelBeat     = BusBeatReady;
          DCacheBusAck = w_last;
        end
        // Requester RW is deliberately not consulted here: a withdrawn
        // request still runs the burst to completion.
        if (w_last) begin
          w_next = ((r_state == GNT_D) && r_write) ? HOLD_D : IDLE;
        end
      end

      HOLD_D: begin
        // Only the D$ may be granted here, regardless of policy.
        if (w_dreq) begin
          w_next    = GNT_D;
          w_grant_d = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end

      default: w_next = IDLE;
    endcase

    // A reset arriving mid-burst aborts it: no beat, last or ack escapes.
    if (reset) begin
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      w_last       = 1'b0;
      w_owned      = 1'b0;
      BusReq       = 1'b0;
      BusWrite     = 1'b0;
      BusAdr       = '0;
      BeatCount    = '0;
      BusLast      = 1'b0;
      ICacheBusAck = 1'b0;
      DCacheBusAck = 1'b0;
      ISelBeat     = 1'b0;
      DSelBeat     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_write <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_d) begin
        r_adr   <= DCacheBusAdr;
        r_write <= DCacheBusRW[0];
        r_beat  <= '0;
      end else if (w_grant_i) begin
        r_adr   <= ICacheBusAdr;
        r_write <= ICacheBusRW[0];
        r_beat  <= '0;
      end else if (w_owned && BusBeatReady) begin
        r_beat <= w_last ? '0 : (r_beat + BEAT_ONE);
      end
    end
  end

`ifdef CACHEBUSARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cache_bus_arb.sv
// tb/tb_cache_bus_arb.sv - table-driven self-checking bench for cache_bus_arb

module tb_cache_bus_arb;

  localparam int PA_BITS = 34;
  localparam int LOGBWPL = 2;
  localparam logic [PA_BITS-1:0] IA = 34'h0_8000_1000;
  localparam logic [PA_BITS-1:0] DA = 34'h0_8000_2040;

  logic               clk;
  logic               reset;
  logic [1:0]         ICacheBusRW;
  logic [1:0]         DCacheBusRW;
  logic [PA_BITS-1:0] ICacheBusAdr;
  logic [PA_BITS-1:0] DCacheBusAdr;
  logic               BusBeatReady;
  logic               BusReq;
  logic               BusWrite;
  logic [PA_BITS-1:0] BusAdr;
  logic [LOGBWPL-1:0] BeatCount;
  logic               BusLast;
  logic               ICacheBusAck;
  logic               DCacheBusAck;
  logic               ISelBeat;
  logic               DSelBeat;

  cache_bus_arb #(.PA_BITS(PA_BITS), .LOGBWPL(LOGBWPL)) dut (
    .clk          (clk),
    .reset        (reset),
    .ICacheBusRW  (ICacheBusRW),
    .DCacheBusRW  (DCacheBusRW),
    .ICacheBusAdr (ICacheBusAdr),
    .DCacheBusAdr (DCacheBusAdr),
    .BusBeatReady (BusBeatReady),
    .BusReq       (BusReq),
    .BusWrite     (BusWrite),
    .BusAdr       (BusAdr),
    .BeatCount    (BeatCount),
    .BusLast      (BusLast),
    .ICacheBusAck (ICacheBusAck),
    .DCacheBusAck (DCacheBusAck),
    .ISelBeat     (ISelBeat),
    .DSelBeat     (DSelBeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {BusReq, BusWrite, BeatCount[1:0], BusLast, IAck, DAck, ISel, DSel}
  // own = 0 none (BusAdr 0), 1 I$ (IA), 2 D$ (DA)
  typedef struct {
    logic       rst;
    logic [1:0] irw;
    logic [1:0] drw;
    logic       bbr;
    logic [8:0] exp;
    logic [1:0] own;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic void add(input logic rst, input logic [1:0] irw,
                              input logic [1:0] drw, input logic bbr,
                              input logic [8:0] exp, input logic [1:0] own);
    vec_t v;
    v.rst = rst; v.irw = irw; v.drw = drw; v.bbr = bbr;
    v.exp = exp; v.own = own;
    vecs.push_back(v);
  endfunction

  function automatic logic [PA_BITS-1:0] adr_of(input logic [1:0] own);
    return (own == 2'd1) ? IA : (own == 2'd2) ? DA : '0;
  endfunction

  function automatic logic [8:0] outs();
    return {BusReq, BusWrite, BeatCount, BusLast, ICacheBusAck,
            DCacheBusAck, ISelBeat, DSelBeat};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    ICacheBusRW  = 2'b00;
    DCacheBusRW  = 2'b00;
    ICacheBusAdr = IA;
    DCacheBusAdr = DA;
    BusBeatReady = 1'b1;

    // A: lone I$ fetch
    add(0, 2'b10, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_00_0_0_0_1_0, 1);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_01_0_0_0_1_0, 1);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_10_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_11_1_1_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    // B: simultaneous fetch requests, D$ first then I$
    add(0, 2'b10, 2'b10, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b10, 2'b10, 1, 9'b1_0_00_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b10, 1, 9'b1_0_01_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b10, 1, 9'b1_0_10_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_11_1_0_1_0_1, 2);
    add(0, 2'b10, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_00_0_0_0_1_0, 1);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_01_0_0_0_1_0, 1);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_10_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_11_1_1_0_1_0, 1);
    // C: D$ writeback, HOLD_D, D$ fetch, then pending I$
    add(0, 2'b10, 2'b01, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b10, 2'b01, 1, 9'b1_1_00_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b01, 1, 9'b1_1_01_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b01, 1, 9'b1_1_10_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b10, 1, 9'b1_1_11_1_0_1_0_1, 2);
    add(0, 2'b10, 2'b10, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b10, 2'b10, 1, 9'b1_0_00_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b10, 1, 9'b1_0_01_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b10, 1, 9'b1_0_10_0_0_0_0_1, 2);
    add(0, 2'b10, 2'b00, 1, 9'b1_0_11_1_0_1_0_1, 2);
    add(0, 2'b10, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    // I$ withdraws right after grant; burst still completes
    add(0, 2'b00, 2'b00, 1, 9'b1_0_00_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_01_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_10_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_11_1_1_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    // D: BusBeatReady toggling
    add(0, 2'b10, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_00_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 0, 9'b1_0_01_0_0_0_0_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_01_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 0, 9'b1_0_10_0_0_0_0_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_10_0_0_0_1_0, 1);
    add(0, 2'b00, 2'b00, 0, 9'b1_0_11_0_0_0_0_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b1_0_11_1_1_0_1_0, 1);
    add(0, 2'b00, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    // E: reset at BeatCount=2 of a D$ burst
    add(0, 2'b00, 2'b10, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b00, 2'b10, 1, 9'b1_0_00_0_0_0_0_1, 2);
    add(0, 2'b00, 2'b10, 1, 9'b1_0_01_0_0_0_0_1, 2);
    add(1, 2'b00, 2'b10, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b00, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);
    add(0, 2'b00, 2'b00, 1, 9'b0_0_00_0_0_0_0_0, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", {55'd0, outs()}, 64'd0);
    chk("reset_adr", {30'd0, BusAdr}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      ICacheBusRW = vecs[i].irw;
      DCacheBusRW = vecs[i].drw;
      BusBeatReady = vecs[i].bbr;
      #1;
      chk($sformatf("vec%0d", i), {21'd0, outs(), BusAdr},
          {21'd0, vecs[i].exp, adr_of(vecs[i].own)});
    end

    // Repeated contention after reset: policy decides the second winner.
    @(negedge clk);
    reset = 1'b1; ICacheBusRW = 2'b00; DCacheBusRW = 2'b00; BusBeatReady = 1'b1;
    @(negedge clk);
    reset = 1'b0; ICacheBusRW = 2'b10; DCacheBusRW = 2'b10;
    #1;
    chk("rr_idle", {63'd0, BusReq}, 64'd0);
    @(negedge clk); #1;
    chk("rr_first_owner", {27'd0, BusReq, ISelBeat, DSelBeat, BusAdr},
        {27'd0, 3'b101, DA});
    repeat (3) @(negedge clk);
    #1;
    chk("rr_first_ack", {61'd0, BusLast, ICacheBusAck, DCacheBusAck},
        {61'd0, 3'b101});
    @(negedge clk); #1;
    chk("rr_gap", {63'd0, BusReq}, 64'd0);
    @(negedge clk); #1;
`ifdef CACHEBUSARB_ROUND_ROBIN_EN
    chk("rr_second_owner", {27'd0, BusReq, ISelBeat, DSelBeat, BusAdr},
        {27'd0, 3'b110, IA});
`else
    chk("rr_second_owner", {27'd0, BusReq, ISelBeat, DSelBeat, BusAdr},
        {27'd0, 3'b101, DA});
`endif
    ICacheBusRW = 2'b00; DCacheBusRW = 2'b00;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
